// File: rtl/lane_readout_scheduler.sv
// rtl/lane_readout_scheduler.sv - round-robin arbiter sharing one readout engine across lanes
// Optional macro LANE_SCHED_STATS_EN adds saturating grant/timeout counters with stats_clr.
module lane_readout_scheduler #(
  parameter int NLANES         = 20,
  parameter int LANE_W         = 5,
  parameter int HOLD_SETUP     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              resn,
  input  logic              enable,
  input  logic [NLANES-1:0] lane_enable,
  input  logic [NLANES-1:0] lane_interruptn,
  output logic [NLANES-1:0] lane_hold,
  output logic              rd_req,
  output logic [LANE_W-1:0] rd_lane,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              busy,
`ifdef LANE_SCHED_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       grant_cnt,
  output logic [15:0]       timeout_cnt,
`endif
  output logic              timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > HOLD_SETUP) ? TIMEOUT_CYCLES : HOLD_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TMAX       = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(HOLD_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [NLANES-1:0]   int_sync1, int_sync2;
  logic [NLANES-1:0]   pending;
  logic [NLANES-1:0]   hold_nx;
  logic [LANE_W-1:0]   last_grant, last_nx;
  logic [LANE_W-1:0]   lane_nx;
  logic                req_nx, busy_nx, terr_nx;
  logic                win_valid;
  logic [LANE_W-1:0]   win_idx;
  logic [LANE_W:0]     cand;

  assign pending = lane_enable & ~int_sync2;

  // Search starts just after the last granted lane so every requester gets a turn.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NLANES; i++) begin
      cand = {1'b0, last_grant} + (LANE_W+1)'(i);
      if (cand >= (LANE_W+1)'(NLANES))
        cand = cand - (LANE_W+1)'(NLANES);
      if (!win_valid && pending[cand[LANE_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[LANE_W-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hold_nx  = lane_hold;
    req_nx   = rd_req;
    lane_nx  = rd_lane;
    busy_nx  = busy;
    last_nx  = last_grant;
    terr_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && win_valid) begin
          lane_nx  = win_idx;
          hold_nx  = NLANES'(1) << win_idx;
          busy_nx  = 1'b1;
          cnt_nx   = SETUP_LOAD;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          req_nx   = 1'b1;
          state_nx = S_REQ;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_REQ: begin
        if (rd_ack) begin
          req_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = S_WAIT;
        end else if (cnt == TMAX) begin
          req_nx   = 1'b0;
          terr_nx  = 1'b1;
          state_nx = S_RELEASE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // done on the expiry cycle still counts as success
        if (rd_done) begin
          state_nx = S_RELEASE;
        end else if (cnt == TMAX) begin
          terr_nx  = 1'b1;
          state_nx = S_RELEASE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        hold_nx  = '0;
        busy_nx  = 1'b0;
        last_nx  = rd_lane;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      int_sync1   <= '1;
      int_sync2   <= '1;
      lane_hold   <= '0;
      rd_req      <= 1'b0;
      rd_lane     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= LANE_W'(NLANES - 1);
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      int_sync1   <= lane_interruptn;
      int_sync2   <= int_sync1;
      lane_hold   <= hold_nx;
      rd_req      <= req_nx;
      rd_lane     <= lane_nx;
      busy        <= busy_nx;
      timeout_err <= terr_nx;
      last_grant  <= last_nx;
    end
  end

`ifdef LANE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      grant_cnt   <= '0;
      timeout_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      if (state == S_IDLE && state_nx == S_SETUP && grant_cnt != 16'hFFFF)
        grant_cnt <= grant_cnt + 16'd1;
      if (terr_nx && timeout_cnt != 16'hFFFF)
        timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_lane_readout_scheduler.sv
// tb/tb_lane_readout_scheduler.sv - directed self-checking bench for lane_readout_scheduler
module tb_lane_readout_scheduler;

  logic        clk;
  logic        resn;
  logic        enable;
  logic [19:0] lane_enable;
  logic [19:0] lane_interruptn;
  logic [19:0] lane_hold;
  logic        rd_req;
  logic [4:0]  rd_lane;
  logic        rd_ack;
  logic        rd_done;
  logic        busy;
  logic        timeout_err;
`ifdef LANE_SCHED_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt;
  logic [15:0] timeout_cnt;
`endif

  int total = 0;
  int bad = 0;
  int terr_pulses = 0;
  int multi_hold = 0;

  logic [4:0]  g_lane;
  logic [19:0] g_hold;
  logic [19:0] h_done;
  int          setup_cyc;
  int          to_cyc;
  bit          ok;

  lane_readout_scheduler #(
    .NLANES(20),
    .LANE_W(5),
    .HOLD_SETUP(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .resn(resn),
    .enable(enable),
    .lane_enable(lane_enable),
    .lane_interruptn(lane_interruptn),
    .lane_hold(lane_hold),
    .rd_req(rd_req),
    .rd_lane(rd_lane),
    .rd_ack(rd_ack),
    .rd_done(rd_done),
    .busy(busy),
`ifdef LANE_SCHED_STATS_EN
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt),
    .timeout_cnt(timeout_cnt),
`endif
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timeout_err) terr_pulses++;
    if ($countones(lane_hold) > 1) multi_hold++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the readout engine for one transaction: ack one cycle after rd_req,
  // done seen done_after cycles after the ack edge (or never).
  task automatic do_txn(input logic [19:0] release_mask, input bit drop_en, input bit send_done,
                        input int done_after);
    int n;
    ok = 1'b1; to_cyc = -1; setup_cyc = -1; g_lane = '0; g_hold = '0; h_done = '0;
    n = 0;
    while (lane_hold == 20'h0 && n < 60) begin tick(); n++; end
    if (lane_hold == 20'h0) begin ok = 1'b0; return; end
    g_hold = lane_hold;
    g_lane = rd_lane;
    lane_interruptn = lane_interruptn | release_mask;
    n = 0;
    while (!rd_req && n < 20) begin tick(); n++; end
    setup_cyc = n;
    if (!rd_req) begin ok = 1'b0; return; end
    tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    if (drop_en) enable = 1'b0;
    if (send_done) begin
      repeat (done_after - 1) tick();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      h_done = lane_hold;
      tick();
    end else begin
      n = 0;
      while (!timeout_err && n < 40) begin tick(); n++; end
      if (timeout_err) to_cyc = n; else ok = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    resn = 1'b0; enable = 1'b0; lane_enable = '1; lane_interruptn = '1;
    rd_ack = 1'b0; rd_done = 1'b0;
`ifdef LANE_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) tick();
    total++;
    if ({lane_hold, rd_req, rd_lane, busy, timeout_err} !== 28'h0) begin
      bad++;
      $display("FAIL reset_outputs: hold=%h req=%b lane=%0d busy=%b terr=%b want all zero",
               lane_hold, rd_req, rd_lane, busy, timeout_err);
    end
`ifdef LANE_SCHED_STATS_EN
    total++;
    if (grant_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_stats: grant_cnt=%0d timeout_cnt=%0d want 0 0", grant_cnt, timeout_cnt);
    end
`endif
    resn = 1'b1;
    enable = 1'b1;
    rd_ack = 1'b1; rd_done = 1'b1;
    repeat (3) tick();
    rd_ack = 1'b0; rd_done = 1'b0;
    total++;
    if (busy !== 1'b0 || rd_req !== 1'b0 || lane_hold !== 20'h0) begin
      bad++;
      $display("FAIL idle_ignores_ack_done: busy=%b req=%b hold=%h want 0 0 0", busy, rd_req, lane_hold);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_lane [5];
    exp_lane[0] = 5'd0; exp_lane[1] = 5'd5; exp_lane[2] = 5'd19;
    exp_lane[3] = 5'd0; exp_lane[4] = 5'd5;
    lane_interruptn[0] = 1'b0; lane_interruptn[5] = 1'b0; lane_interruptn[19] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_txn((i == 4) ? 20'hFFFFF : 20'h0, 1'b0, 1'b1, 3);
      total++;
      if (!ok || g_lane !== exp_lane[i] || g_hold !== (20'h1 << exp_lane[i])) begin
        bad++;
        $display("FAIL rr_grant_%0d: lane=%0d hold=%h ok=%b want lane=%0d", i, g_lane, g_hold, ok, exp_lane[i]);
      end
    end
    total++;
    if (multi_hold !== 0) begin
      bad++;
      $display("FAIL rr_onehot: cycles with >1 hold bit=%0d want 0", multi_hold);
    end
  endtask

  task automatic test_single_lane();
    int pulses_before;
    pulses_before = terr_pulses;
    repeat (3) tick();
    lane_interruptn[3] = 1'b0;
    do_txn(20'h8, 1'b0, 1'b1, 10);
    total++;
    if (!ok || g_hold !== 20'h00008 || g_lane !== 5'd3) begin
      bad++;
      $display("FAIL single_grant: hold=%h lane=%0d ok=%b want hold=00008 lane=3", g_hold, g_lane, ok);
    end
    total++;
    if (setup_cyc !== 4) begin
      bad++;
      $display("FAIL single_setup: hold-to-req cycles=%0d want 4", setup_cyc);
    end
    total++;
    if (h_done !== 20'h00008 || lane_hold !== 20'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_release: hold_at_done=%h hold_after=%h busy=%b want 00008 00000 0",
               h_done, lane_hold, busy);
    end
    total++;
    if (terr_pulses !== pulses_before) begin
      bad++;
      $display("FAIL single_no_timeout: pulses=%0d want %0d", terr_pulses, pulses_before);
    end
  endtask

  task automatic test_mask_enable();
    int held;
    lane_enable[5] = 1'b0;
    lane_interruptn[5] = 1'b0; lane_interruptn[7] = 1'b0;
    do_txn(20'h0, 1'b0, 1'b1, 4);
    total++;
    if (!ok || g_lane !== 5'd7) begin
      bad++;
      $display("FAIL mask_first: lane=%0d ok=%b want 7", g_lane, ok);
    end
    do_txn(20'h0, 1'b1, 1'b1, 4);
    total++;
    if (!ok || g_lane !== 5'd7 || lane_hold !== 20'h0) begin
      bad++;
      $display("FAIL mask_disable_completes: lane=%0d hold=%h ok=%b want 7 00000", g_lane, lane_hold, ok);
    end
    held = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (lane_hold != 20'h0 || busy) held++;
    end
    total++;
    if (held !== 0) begin
      bad++;
      $display("FAIL disabled_no_grant: busy cycles=%0d want 0", held);
    end
    enable = 1'b1;
    do_txn(20'hFFFFF, 1'b0, 1'b1, 4);
    total++;
    if (!ok || g_lane !== 5'd7) begin
      bad++;
      $display("FAIL reenable_grant: lane=%0d ok=%b want 7", g_lane, ok);
    end
    repeat (4) tick();
    lane_enable = '1;
  endtask

  task automatic test_timeout();
    int pulses_before;
    pulses_before = terr_pulses;
    lane_interruptn[9] = 1'b0; lane_interruptn[2] = 1'b0;
    do_txn(20'h200, 1'b0, 1'b0, 0);
    total++;
    if (!ok || g_lane !== 5'd9 || to_cyc !== 16) begin
      bad++;
      $display("FAIL timeout_latency: lane=%0d cycles=%0d ok=%b want 9 16", g_lane, to_cyc, ok);
    end
    total++;
    if (timeout_err !== 1'b0 || lane_hold !== 20'h0 || terr_pulses !== pulses_before + 1) begin
      bad++;
      $display("FAIL timeout_release: terr=%b hold=%h pulses=%0d want 0 00000 %0d",
               timeout_err, lane_hold, terr_pulses, pulses_before + 1);
    end
    do_txn(20'h4, 1'b0, 1'b1, 16);
    total++;
    if (!ok || g_lane !== 5'd2) begin
      bad++;
      $display("FAIL timeout_next_grant: lane=%0d ok=%b want 2", g_lane, ok);
    end
    total++;
    if (terr_pulses !== pulses_before + 1) begin
      bad++;
      $display("FAIL done_at_expiry: pulses=%0d want %0d", terr_pulses, pulses_before + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    lane_interruptn[12] = 1'b0;
    n = 0;
    while (lane_hold == 20'h0 && n < 30) begin tick(); n++; end
    total++;
    if (lane_hold !== 20'h01000 || rd_lane !== 5'd12) begin
      bad++;
      $display("FAIL midreset_grant: hold=%h lane=%0d want 01000 12", lane_hold, rd_lane);
    end
    tick();
    #2;
    resn = 1'b0;
    #1;
    total++;
    if (lane_hold !== 20'h0 || rd_req !== 1'b0 || busy !== 1'b0 || rd_lane !== 5'd0) begin
      bad++;
      $display("FAIL midreset_async: hold=%h req=%b busy=%b lane=%0d want 0 0 0 0",
               lane_hold, rd_req, busy, rd_lane);
    end
    lane_interruptn[0] = 1'b0;
    tick();
    tick();
    resn = 1'b1;
    do_txn(20'h01001, 1'b0, 1'b1, 4);
    total++;
    if (!ok || g_lane !== 5'd0) begin
      bad++;
      $display("FAIL midreset_first_lane0: lane=%0d ok=%b want 0", g_lane, ok);
    end
  endtask

`ifdef LANE_SCHED_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    lane_interruptn[4] = 1'b0;
    do_txn(20'h0, 1'b0, 1'b1, 4);
    do_txn(20'h0, 1'b0, 1'b0, 0);
    do_txn(20'h10, 1'b0, 1'b1, 4);
    total++;
    if (grant_cnt !== 16'd3 || timeout_cnt !== 16'd1) begin
      bad++;
      $display("FAIL stats_count: grant_cnt=%0d timeout_cnt=%0d want 3 1", grant_cnt, timeout_cnt);
    end
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    total++;
    if (grant_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin
      bad++;
      $display("FAIL stats_clear: grant_cnt=%0d timeout_cnt=%0d want 0 0", grant_cnt, timeout_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_lane();
    test_mask_enable();
    test_timeout();
    test_reset_mid();
`ifdef LANE_SCHED_STATS_EN
    test_stats();
`endif
    total++;
    if (multi_hold !== 0) begin
      bad++;
      $display("FAIL final_onehot: cycles with >1 hold bit=%0d want 0", multi_hold);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
